// File: rtl/op_sequencer.sv
// op_sequencer: queues 32-bit controller instructions and sequences them (multiply, page load, page read) onto a compute controller.
// Optional macro OP_SEQUENCER_ERR_EN adds a sticky illegal-opcode flag output err.
module op_sequencer #(
  parameter int DEPTH       = 4,
  parameter int PAGE_WORDS  = 64,
  parameter int MULT_CYCLES = 600,
  parameter int READ_LAT    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_op,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_data,
  output logic        ctrl_enable,
  output logic [31:0] operation,
  output logic [31:0] in_data,
  input  logic [31:0] out_data,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        busy,
  output logic        done
`ifdef OP_SEQUENCER_ERR_EN
  ,
  output logic        err
`endif
);

  localparam int PW      = $clog2(DEPTH);
  localparam int CNT_MAX = (MULT_CYCLES > PAGE_WORDS) ? MULT_CYCLES : PAGE_WORDS;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] MULT_LAST = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] PAGE_LAST = CW'(PAGE_WORDS - 1);
  localparam logic [PW:0]   FIFO_FULL = (PW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_GAP  = 3'd1,
    S_LOAD = 3'd2,
    S_MULT = 3'd3,
    S_READ = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   fifo_mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;
  logic [31:0]   op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic push, pop, empty, full;
  logic rd_issue, rd_issue_last, done_exec;
  logic rd_last_out, rd_pend;

  assign empty     = (count_q == (PW + 1)'(0));
  assign full      = (count_q == FIFO_FULL);
  assign cmd_ready = ~full;
  assign push      = cmd_valid & ~full;
  assign pop       = (state_q == S_IDLE) & ~empty;

  // Command FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= PW'(0);
      rd_ptr_q <= PW'(0);
      count_q  <= (PW + 1)'(0);
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PW + 1)'(1);
        2'b01:   count_q <= count_q - (PW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Command FIFO storage
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= cmd_op;
  end

  // Sequencer state, active command word and cycle/word counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= 32'h0;
      cnt_q   <= CW'(0);
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and controller-facing outputs; GAP guarantees a 0 -> opcode edge per command
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    cnt_d         = cnt_q;
    operation     = 32'h0;
    ctrl_enable   = 1'b1;
    wr_ready      = 1'b0;
    in_data       = 32'h0;
    rd_issue      = 1'b0;
    rd_issue_last = 1'b0;
    done_exec     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          op_d    = fifo_mem_q[rd_ptr_q];
          state_d = S_GAP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        cnt_d = CW'(0);
        case (op_q[3:0])
          4'd1:    state_d = S_MULT;
          4'd2:    state_d = S_LOAD;
          4'd3:    state_d = S_READ;
          default: state_d = S_IDLE;
        endcase
      end
      S_MULT: begin
        operation = op_q;
        if (cnt_q == MULT_LAST) begin
          done_exec = 1'b1;
          cnt_d     = CW'(0);
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_LOAD: begin
        operation   = op_q;
        wr_ready    = 1'b1;
        ctrl_enable = wr_valid;
        in_data     = wr_data;
        if (wr_valid) begin
          if (cnt_q == PAGE_LAST) begin
            done_exec = 1'b1;
            cnt_d     = CW'(0);
            state_d   = S_IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_READ: begin
        operation = op_q;
        rd_issue  = 1'b1;
        if (cnt_q == PAGE_LAST) begin
          rd_issue_last = 1'b1;
          cnt_d         = CW'(0);
          state_d       = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  generate
    if (READ_LAT == 0) begin : g_rd_comb
      assign rd_valid    = rd_issue;
      assign rd_last_out = rd_issue_last;
      assign rd_pend     = 1'b0;
    end else begin : g_rd_pipe
      logic [READ_LAT-1:0] vld_q, last_q;

      // Delay line aligning each read cycle with the controller's out_data
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          vld_q  <= {READ_LAT{1'b0}};
          last_q <= {READ_LAT{1'b0}};
        end else begin
          vld_q[0]  <= rd_issue;
          last_q[0] <= rd_issue_last;
          for (int i = 1; i < READ_LAT; i++) begin
            vld_q[i]  <= vld_q[i-1];
            last_q[i] <= last_q[i-1];
          end
        end
      end

      assign rd_valid    = vld_q[READ_LAT-1];
      assign rd_last_out = last_q[READ_LAT-1];
      assign rd_pend     = |vld_q;
    end
  endgenerate

  // A read completes only once its final word has been delivered
  assign rd_data = rd_valid ? out_data : 32'h0;
  assign done    = done_exec | rd_last_out;
  assign busy    = (state_q != S_IDLE) | ~empty | rd_pend;

`ifdef OP_SEQUENCER_ERR_EN
  logic err_q;
  logic gap_illegal;

  assign gap_illegal = (state_q == S_GAP) &
                       ~((op_q[3:0] == 4'd1) | (op_q[3:0] == 4'd2) | (op_q[3:0] == 4'd3));

  // Sticky illegal-opcode flag, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (gap_illegal) begin
      err_q <= 1'b1;
    end else begin
      err_q <= err_q;
    end
  end

  assign err = err_q | gap_illegal;
`endif

endmodule

// File: tb/tb_op_sequencer.sv
// Directed self-checking bench for op_sequencer with a simple controller model answering reads with 0xA0+n.
module tb_op_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_op;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic        ctrl_enable;
  logic [31:0] operation, in_data, out_data;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        busy, done;
`ifdef OP_SEQUENCER_ERR_EN
  logic        err;
`endif

  int total = 0;
  int bad   = 0;

  op_sequencer #(
    .DEPTH(4), .PAGE_WORDS(64), .MULT_CYCLES(600), .READ_LAT(1)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .ctrl_enable(ctrl_enable), .operation(operation), .in_data(in_data), .out_data(out_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy), .done(done)
`ifdef OP_SEQUENCER_ERR_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  // Controller model: each enabled read-opcode cycle returns 0xA0+n on the next cycle
  int unsigned ctl_n;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data <= 32'h0;
      ctl_n    <= 0;
    end else if (operation == 32'h0) begin
      ctl_n <= 0;
    end else if (ctrl_enable && operation[3:0] == 4'h3) begin
      out_data <= 32'hA0 + ctl_n;
      ctl_n    <= ctl_n + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  int zeros, ones, done_at, dones, en_bad, busy_after, in_bad, op_bad;
  int word, acc, done_word, rv_cnt, data_bad, lag_bad, done_ok, nz, busy_cnt;
  int err_first, seen7, p, nseg, zrun, ready_after4, idle_ready;
  logic prev_done, prev_rd;
  logic [31:0] cur;
  logic [31:0] exp_ops [6];
  int          exp_len [6];
  logic [31:0] seg_val [6];
  int          seg_zero [6];
  int          seg_len [6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_valid = 1'b0; cmd_op = 32'h0; wr_valid = 1'b0; wr_data = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_operation", operation, 0);
    check("rst_in_data", in_data, 0);
    check("rst_ctrl_enable", ctrl_enable, 1);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
`ifdef OP_SEQUENCER_ERR_EN
    check("rst_err", err, 0);
`endif
    @(negedge clk); reset = 1'b0;

    // ---- multiply command: 2 zero cycles, 600 opcode cycles, done on the last
    @(negedge clk); cmd_valid = 1'b1; cmd_op = 32'h1;
    @(negedge clk); cmd_valid = 1'b0; cmd_op = 32'h0;
    zeros = 0; ones = 0; done_at = -1; dones = 0; en_bad = 0; busy_after = -1; prev_done = 1'b0;
    for (int c = 0; c < 700; c++) begin
      #1;
      if (prev_done) busy_after = int'(busy);
      if (operation == 32'h0 && ones == 0) zeros++;
      if (operation == 32'h1) begin
        ones++;
        if (!ctrl_enable) en_bad++;
      end
      if (done) begin dones++; done_at = ones; end
      prev_done = done;
      @(negedge clk);
    end
    check("mult_zero_cycles", zeros, 2);
    check("mult_op_cycles", ones, 600);
    check("mult_done_cycle", done_at, 600);
    check("mult_done_count", dones, 1);
    check("mult_busy_after_done", busy_after, 0);
    check("mult_enable", en_bad, 0);

    // ---- page load: wr_valid low every third cycle
    @(negedge clk); cmd_valid = 1'b1; cmd_op = 32'h2;
    @(negedge clk); cmd_valid = 1'b0; cmd_op = 32'h0;
    word = 1; acc = 0; en_bad = 0; in_bad = 0; op_bad = 0; dones = 0; done_word = -1;
    for (int c = 0; c < 300; c++) begin
      wr_valid = ((c % 3) != 2);
      wr_data  = word;
      #1;
      if (wr_ready) begin
        if (ctrl_enable !== wr_valid) en_bad++;
        if (wr_valid && in_data !== word) in_bad++;
        if (operation !== 32'h2) op_bad++;
      end else if (in_data !== 32'h0) begin
        in_bad++;
      end
      if (done) begin
        dones++;
        done_word = (wr_ready && wr_valid) ? word : -1;
      end
      if (wr_ready && wr_valid) begin acc++; word++; end
      @(negedge clk);
    end
    wr_valid = 1'b0; wr_data = 32'h0;
    check("load_words", acc, 64);
    check("load_enable_tracks_valid", en_bad, 0);
    check("load_in_data_seq", in_bad, 0);
    check("load_operation", op_bad, 0);
    check("load_done_count", dones, 1);
    check("load_done_word", done_word, 64);

    // ---- page read: 64 rd_valid pulses lagging one cycle, data 0xA0..0xDF
    @(negedge clk); cmd_valid = 1'b1; cmd_op = 32'h3;
    @(negedge clk); cmd_valid = 1'b0; cmd_op = 32'h0;
    rv_cnt = 0; data_bad = 0; lag_bad = 0; dones = 0; done_ok = 0; prev_rd = 1'b0;
    for (int c = 0; c < 200; c++) begin
      #1;
      if (rd_valid !== prev_rd) lag_bad++;
      if (rd_valid) begin
        if (rd_data !== 32'hA0 + rv_cnt) data_bad++;
        rv_cnt++;
      end
      if (done) begin
        dones++;
        done_ok = int'(rd_valid && rv_cnt == 64);
      end
      prev_rd = (operation == 32'h3) && ctrl_enable;
      @(negedge clk);
    end
    check("read_pulses", rv_cnt, 64);
    check("read_data", data_bad, 0);
    check("read_lag", lag_bad, 0);
    check("read_done_count", dones, 1);
    check("read_done_on_last", done_ok, 1);

    // ---- illegal opcode 0x7 followed by a multiply
`ifdef OP_SEQUENCER_ERR_EN
    check("err_before_illegal", err, 0);
`endif
    @(negedge clk); cmd_valid = 1'b1; cmd_op = 32'h7;
    @(negedge clk);
    zeros = 0; ones = 0; dones = 0; seen7 = 0; err_first = -1;
    for (int c = 0; c < 700; c++) begin
      if (c == 0) cmd_op = 32'h1;
      if (c == 1) begin cmd_valid = 1'b0; cmd_op = 32'h0; end
      #1;
      if (operation == 32'h0 && ones == 0) zeros++;
      if (operation == 32'h1) ones++;
      if (operation == 32'h7) seen7++;
      if (done) dones++;
`ifdef OP_SEQUENCER_ERR_EN
      if (err === 1'b1 && err_first < 0) err_first = c;
`endif
      @(negedge clk);
    end
    check("illegal_zero_cycles", zeros, 4);
    check("illegal_not_driven", seen7, 0);
    check("illegal_next_mult", ones, 600);
    check("illegal_done_count", dones, 1);
`ifdef OP_SEQUENCER_ERR_EN
    check("err_rise_cycle", err_first, 1);
    check("err_sticky", err, 1);
`endif

    // ---- queue: one running command plus five queued, FIFO depth 4
    exp_ops = '{32'h001, 32'h103, 32'h201, 32'h303, 32'h403, 32'h501};
    exp_len = '{600, 64, 600, 64, 64, 600};
    for (int i = 0; i < 6; i++) begin seg_val[i] = 32'h0; seg_zero[i] = -1; seg_len[i] = 0; end
    @(negedge clk); cmd_valid = 1'b1; cmd_op = exp_ops[0];
    p = 1; nseg = 0; zrun = 0; cur = 32'h0; ready_after4 = -1; idle_ready = -1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (p < 6) begin cmd_valid = 1'b1; cmd_op = exp_ops[p]; end
      else begin cmd_valid = 1'b0; cmd_op = 32'h0; end
      #1;
      if (p == 5 && ready_after4 < 0) ready_after4 = int'(cmd_ready);
      if (operation == 32'h0) begin
        if (nseg == 1 && cur != 32'h0 && idle_ready < 0) idle_ready = int'(cmd_ready);
        zrun++;
      end else if (operation != cur) begin
        if (nseg < 6) begin seg_val[nseg] = operation; seg_zero[nseg] = zrun; seg_len[nseg] = 1; end
        nseg++;
        zrun = 0;
      end else if (nseg > 0 && nseg <= 6) begin
        seg_len[nseg-1]++;
      end
      cur = operation;
      if (cmd_valid && cmd_ready) p++;
      if (nseg >= 6 && !busy) break;
    end
    cmd_valid = 1'b0;
    check("fifo_ready_low_when_full", ready_after4, 0);
    check("fifo_ready_low_full_pop", idle_ready, 0);
    check("fifo_accepted", p, 6);
    check("fifo_segments", nseg, 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("seg%0d_op", i), seg_val[i], exp_ops[i]);
      check($sformatf("seg%0d_zero_gap", i), seg_zero[i], 2);
      check($sformatf("seg%0d_len", i), seg_len[i], exp_len[i]);
    end

    // ---- reset in MULT cycle 100 with two commands queued
    @(negedge clk); cmd_valid = 1'b1; cmd_op = 32'h1;
    @(negedge clk); cmd_op = 32'h3;
    @(negedge clk); cmd_op = 32'h3;
    @(negedge clk); cmd_valid = 1'b0; cmd_op = 32'h0;
    repeat (99) @(negedge clk);
    #1;
    check("pre_reset_operation", operation, 1);
    check("pre_reset_busy", busy, 1);
    #2; reset = 1'b1;
    #1;
    check("midrst_operation", operation, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_cmd_ready", cmd_ready, 1);
    check("midrst_ctrl_enable", ctrl_enable, 1);
`ifdef OP_SEQUENCER_ERR_EN
    check("midrst_err_cleared", err, 0);
`endif
    @(negedge clk); reset = 1'b0;
    nz = 0; dones = 0; busy_cnt = 0;
    for (int c = 0; c < 700; c++) begin
      #1;
      if (operation != 32'h0) nz++;
      if (done) dones++;
      if (busy) busy_cnt++;
      @(negedge clk);
    end
    check("postrst_no_exec", nz, 0);
    check("postrst_no_done", dones, 0);
    check("postrst_idle", busy_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/op_sequencer.md
OP_SEQUENCER -- requirements
Module: op_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4: command FIFO entries, power of 2, at least 2.
REQ-002 SHALL have parameter PAGE_WORDS, default 64: words per serial page load/read.
REQ-003 SHALL have parameter MULT_CYCLES, default 600: cycles opcode 1 is held.
REQ-004 SHALL have parameter READ_LAT, default 1: controller out_data latency after each read cycle.
REQ-005 SHALL have ports, in order: clk in 1, single clock; reset in 1, asynchronous active-high.
REQ-006 SHALL have ports: cmd_valid in 1; cmd_ready out 1; cmd_op in 32, controller instruction word.
REQ-007 SHALL have ports: wr_valid in 1; wr_ready out 1; wr_data in 32, page payload for opcode 2.
REQ-008 SHALL have ports: ctrl_enable out 1; operation out 32; in_data out 32; out_data in 32, from controller.
REQ-009 SHALL have ports: rd_valid out 1; rd_data out 32; busy out 1; done out 1, one-cycle pulse.

Function
REQ-010 SHALL accept a command into the FIFO on cmd_valid && cmd_ready; cmd_ready = FIFO not full.
REQ-011 SHALL, with the FIFO full and a pop in the same cycle, hold cmd_ready low; no accept that cycle.
REQ-012 SHALL implement states IDLE, GAP, LOAD, MULT, READ.
REQ-013 IDLE: operation=0, ctrl_enable=1; pop FIFO head when non-empty and go to GAP.
REQ-014 GAP: one cycle, operation=0, so the controller always sees a 0->nonzero opcode edge; next state decoded from the popped cmd_op[3:0]: 1->MULT, 2->LOAD, 3->READ, other->IDLE with no action.
REQ-015 MULT: operation=popped word for exactly MULT_CYCLES cycles, ctrl_enable=1, then IDLE.
REQ-016 LOAD: operation=popped word; wr_ready=1; ctrl_enable=wr_valid; in_data=wr_data.
REQ-017 LOAD: count accepted words (wr_valid && wr_ready); after the PAGE_WORDS-th word go to IDLE; wr_ready=0 in all other states.
REQ-018 READ: operation=popped word and ctrl_enable=1 for exactly PAGE_WORDS cycles, then IDLE; no backpressure on read data.
REQ-019 SHALL raise rd_valid exactly READ_LAT cycles after each READ cycle, with rd_data=out_data that cycle; exactly PAGE_WORDS rd_valid pulses per read command.
REQ-020 SHALL pulse done for one cycle on the last cycle of MULT, LOAD, or READ, and after the final rd_valid of READ when READ_LAT>0 (done then coincides with the final rd_valid).
REQ-021 busy SHALL be high when state is not IDLE, or the FIFO is non-empty, or rd_valid pulses are pending.
REQ-022 in_data SHALL be 0 outside LOAD.
REQ-023 Counters SHALL be sized for MULT_CYCLES and PAGE_WORDS without wrap; FIFO pointers wrap modulo DEPTH.
REQ-024 Back-to-back commands SHALL always be separated by one IDLE plus one GAP cycle (2 cycles at operation=0).

Reset
REQ-025 On reset assertion, asynchronously: state=IDLE, FIFO empty, counters=0, read pipeline cleared.
REQ-026 Reset outputs: operation=0, in_data=0, ctrl_enable=1, cmd_ready=1, wr_ready=0, rd_valid=0, rd_data=0, busy=0, done=0.
REQ-027 Reset mid-command SHALL abandon the command; queued commands are discarded.

Configuration
REQ-028 Macro OP_SEQUENCER_ERR_EN defined: adds output err (1 bit, sticky, reset 0), set in the GAP cycle of an illegal opcode (0 or >3) and cleared only by reset.
REQ-029 Macro undefined: no err port; illegal opcodes are silently dropped per REQ-014.

Verification
REQ-030 Push cmd_op=0x00000001 with MULT_CYCLES=600 -> 2 cycles operation=0, then operation=0x1 for 600 cycles, done on cycle 600, busy falls next cycle.
REQ-031 Push cmd_op=0x2 (page 0), feed 64 words 1..64 with wr_valid low every 3rd cycle -> ctrl_enable tracks wr_valid, in_data sequence 1..64, done with the 64th word.
REQ-032 Push cmd_op=0x3, controller model returns 0xA0+n -> 64 rd_valid pulses, 1 cycle lagging, data 0xA0..0xDF.
REQ-033 Push 5 commands with DEPTH=4 while busy -> cmd_ready low after the 4th accept, all executed in order, each preceded by 2 zero-opcode cycles.
REQ-034 Assert reset at cycle 100 of MULT with 2 queued commands -> operation=0 immediately, FIFO empty, no done pulse, busy=0.
REQ-035 With OP_SEQUENCER_ERR_EN, push cmd_op=0x7 then 0x1 -> err rises in the GAP cycle and stays high; the 0x1 command still executes.
